// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings for the memory-access pipeline stage
// Purpose: writeback-source and access-size encodings plus the stage FSM state type.
// Ports: none (package).
package mem_stage_pkg;

  // Writeback source select
  localparam logic [1:0] WB_PC  = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // Access size select
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_FULL = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering, load extension and alignment check
// Purpose: purely combinational lane logic for one data-memory access.
// Ports:
//   addr_lo     in   byte offset of the access within the memory word
//   size        in   access size (SZ_*)
//   load_signed in   sign-extend the load result
//   store_data  in   store operand (low bytes used)
//   rdata       in   word returned by memory
//   be          out  byte enables for the access
//   wdata       out  store operand replicated across every lane
//   load_data   out  selected lanes shifted down and extended to DATA_W
//   misaligned  out  address offset is not a multiple of the access size
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter  int DATA_W = 16,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic [OFF_W-1:0]  addr_lo,
  input  logic [1:0]        size,
  input  logic              load_signed,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic              misaligned
);

  localparam logic [DATA_W-1:0] DATA_ONES = '1;
  localparam logic [NB-1:0]     LANE_ONES = '1;

  int                nb;
  int                off;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sign_bit;

  always_comb begin
    // A 4-byte access on a 16-bit datapath degenerates to a full-word access.
    case (size)
      SZ_BYTE: nb = 1;
      SZ_HALF: nb = 2;
      SZ_WORD: nb = (NB >= 4) ? 4 : NB;
      default: nb = NB;
    endcase

    off        = int'(addr_lo);
    misaligned = (off & (nb - 1)) != 0;
    be         = (LANE_ONES >> (NB - nb)) << off;

    // Lane i carries operand byte (i mod nb); nb is a power of two.
    wdata = '0;
    for (int i = 0; i < NB; i++) begin
      wdata[8*i +: 8] = 8'(store_data >> (8 * (i & (nb - 1))));
    end

    shifted   = rdata >> (8 * off);
    keep      = DATA_ONES >> (DATA_W - 8 * nb);
    // keep ^ (keep >> 1) isolates the top bit of the kept field.
    sign_bit  = |(shifted & (keep ^ (keep >> 1)));
    load_data = shifted & keep;
    if (load_signed && sign_bit) begin
      load_data = load_data | ~keep;
    end
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// rtl/mem_stage_pipe.sv - handshaked memory-access stage with registered MEM/WB output
// Purpose: issues loads/stores over a req/ack memory port, steers byte lanes,
//   extends loads, drops misaligned accesses, aborts stuck accesses on timeout
//   and registers the writeback bundle.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             EX/MEM handshake (in_ready low stalls upstream)
//   alu_result, pc_in, imm_in       writeback candidates; alu_result is also the address
//   store_reg, data_in_src          store operand and its source select
//   mem_rd, mem_wr, num_bytes,
//   load_signed, wb_sel,
//   rd_in, reg_wr_in                instruction control fields
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be               data-memory request (held until mem_ack)
//   mem_ack, mem_rdata              data-memory completion
//   wb_valid, wb_data, wb_rd,
//   wb_reg_wr                       registered writeback bundle
//   misalign_err, timeout_err       single-cycle error pulses
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [DATA_W-1:0]   pc_in,
  input  logic [DATA_W-1:0]   imm_in,
  input  logic [DATA_W-1:0]   store_reg,
  input  logic                data_in_src,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic [1:0]          num_bytes,
  input  logic                load_signed,
  input  logic [1:0]          wb_sel,
  input  logic [REG_W-1:0]    rd_in,
  input  logic                reg_wr_in,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                wb_valid,
  output logic [DATA_W-1:0]   wb_data,
  output logic [REG_W-1:0]    wb_rd,
  output logic                wb_reg_wr,
  output logic                misalign_err,
  output logic                timeout_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;

  // Request register, loaded on every accept
  logic [DATA_W-1:0] req_alu, req_pc, req_imm, req_sdata;
  logic              req_load, req_store, req_signed, req_reg_wr;
  logic [1:0]        req_size, req_wb_sel;
  logic [REG_W-1:0]  req_rd;

  logic              wb_valid_d, wb_reg_wr_d, mis_d, to_d;
  logic [DATA_W-1:0] wb_data_d;
  logic [REG_W-1:0]  wb_rd_d;

  logic [OFF_W-1:0]  al_addr_lo;
  logic [1:0]        al_size;
  logic [NB-1:0]     al_be;
  logic [DATA_W-1:0] al_wdata, al_load;
  logic              al_misaligned;

  function automatic logic [DATA_W-1:0] pick_wb(input logic [1:0] sel,
                                               input logic [DATA_W-1:0] pc,
                                               input logic [DATA_W-1:0] alu,
                                               input logic [DATA_W-1:0] mem,
                                               input logic [DATA_W-1:0] imm);
    case (sel)
      WB_PC:   return pc;
      WB_ALU:  return alu;
      WB_MEM:  return mem;
      default: return imm;
    endcase
  endfunction

  // In IDLE the lane logic only judges alignment of the incoming instruction;
  // in ACCESS it works from the captured request so outputs stay stable.
  assign al_addr_lo = (state_q == ST_IDLE) ? alu_result[OFF_W-1:0] : req_alu[OFF_W-1:0];
  assign al_size    = (state_q == ST_IDLE) ? num_bytes : req_size;

  mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .addr_lo     (al_addr_lo),
    .size        (al_size),
    .load_signed (req_signed),
    .store_data  (req_sdata),
    .rdata       (mem_rdata),
    .be          (al_be),
    .wdata       (al_wdata),
    .load_data   (al_load),
    .misaligned  (al_misaligned)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready    = (state_q == ST_IDLE);
    mem_req     = (state_q == ST_ACCESS);
    accept      = in_valid && in_ready;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data;
    wb_rd_d     = wb_rd;
    wb_reg_wr_d = wb_reg_wr;
    mis_d       = 1'b0;
    to_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!(mem_rd || mem_wr)) begin
            wb_valid_d  = 1'b1;
            wb_rd_d     = rd_in;
            wb_reg_wr_d = reg_wr_in;
            wb_data_d   = pick_wb(wb_sel, pc_in, alu_result, '0, imm_in);
          end else if (al_misaligned) begin
            wb_valid_d  = 1'b1;
            wb_rd_d     = rd_in;
            wb_reg_wr_d = 1'b0;
            wb_data_d   = pick_wb(wb_sel, pc_in, alu_result, '0, imm_in);
            mis_d       = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ack) begin
          state_d     = ST_IDLE;
          wb_valid_d  = 1'b1;
          wb_rd_d     = req_rd;
          wb_data_d   = pick_wb(req_wb_sel, req_pc, req_alu, req_load ? al_load : '0, req_imm);
          wb_reg_wr_d = req_load ? req_reg_wr : (req_reg_wr && (req_wb_sel != WB_MEM));
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d     = ST_IDLE;
          wb_valid_d  = 1'b1;
          wb_rd_d     = req_rd;
          wb_reg_wr_d = 1'b0;
          wb_data_d   = pick_wb(req_wb_sel, req_pc, req_alu, '0, req_imm);
          to_d        = 1'b1;
        end
      end
    endcase
  end

  assign mem_we    = mem_req && req_store;
  assign mem_addr  = mem_req ? {req_alu[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_be    = mem_req ? al_be : '0;
  assign mem_wdata = mem_req ? al_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_alu      <= '0;
      req_pc       <= '0;
      req_imm      <= '0;
      req_sdata    <= '0;
      req_load     <= 1'b0;
      req_store    <= 1'b0;
      req_signed   <= 1'b0;
      req_reg_wr   <= 1'b0;
      req_size     <= '0;
      req_wb_sel   <= '0;
      req_rd       <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_wr    <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_valid     <= wb_valid_d;
      wb_data      <= wb_data_d;
      wb_rd        <= wb_rd_d;
      wb_reg_wr    <= wb_reg_wr_d;
      misalign_err <= mis_d;
      timeout_err  <= to_d;
      if (accept) begin
        req_alu    <= alu_result;
        req_pc     <= pc_in;
        req_imm    <= imm_in;
        req_sdata  <= data_in_src ? store_reg : imm_in;
        // rd+wr together behaves as a store
        req_load   <= mem_rd && !mem_wr;
        req_store  <= mem_wr;
        req_signed <= load_signed;
        req_reg_wr <= reg_wr_in;
        req_size   <= num_bytes;
        req_wb_sel <= wb_sel;
        req_rd     <= rd_in;
      end
    end
  end

endmodule
